// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: ALUOp codes, opcodes, funct codes and field
// positions, plus word-building helpers used by the instruction encoder.
package mips_pkg;

  // ALUOp codes, identical to the ID-stage control decoder outputs
  localparam logic [3:0] ALU_NOOP    = 4'd0;
  localparam logic [3:0] ALU_ADD     = 4'd1;
  localparam logic [3:0] ALU_SUB     = 4'd2;
  localparam logic [3:0] ALU_AND     = 4'd3;
  localparam logic [3:0] ALU_OR      = 4'd4;
  localparam logic [3:0] ALU_MULT    = 4'd5;
  localparam logic [3:0] ALU_XOR     = 4'd6;
  localparam logic [3:0] ALU_NOR     = 4'd7;
  localparam logic [3:0] ALU_SLT     = 4'd8;
  localparam logic [3:0] ALU_BEQ     = 4'd9;
  localparam logic [3:0] ALU_J       = 4'd10;
  localparam logic [3:0] ALU_LW      = 4'd11;
  localparam logic [3:0] ALU_SW      = 4'd12;
  localparam logic [3:0] ALU_ADDI    = 4'd13;
  localparam logic [3:0] ALU_BNE     = 4'd14;
  localparam logic [3:0] ALU_ILLEGAL = 4'd15;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Field LSB positions within the 32-bit instruction word
  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return (32'(OPC_RTYPE) << OPC_LSB) | (32'(rs) << RS_LSB) |
           (32'(rt) << RT_LSB) | (32'(rd) << RD_LSB) | 32'(fn);
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return (32'(opc) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
  endfunction

  function automatic logic [31:0] j_word(input logic [25:0] target);
    return (32'(OPC_J) << OPC_LSB) | 32'(target);
  endfunction

endpackage

// File: rtl/instr_enc_word.sv
// Combinational ALUOp-to-instruction-word encoder; flags the illegal code.
module instr_enc_word
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Pick the instruction format and opcode/funct for the requested ALUOp
  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (op)
      ALU_NOOP:    word = 32'h0;
      ALU_ADD:     word = r_word(rs, rt, rd, FN_ADD);
      ALU_SUB:     word = r_word(rs, rt, rd, FN_SUB);
      ALU_AND:     word = r_word(rs, rt, rd, FN_AND);
      ALU_OR:      word = r_word(rs, rt, rd, FN_OR);
      ALU_MULT:    word = r_word(rs, rt, rd, FN_MULT);
      ALU_XOR:     word = r_word(rs, rt, rd, FN_XOR);
      ALU_NOR:     word = r_word(rs, rt, rd, FN_NOR);
      ALU_SLT:     word = r_word(rs, rt, rd, FN_SLT);
      ALU_BEQ:     word = i_word(OPC_BEQ, rs, rt, imm);
      ALU_J:       word = j_word(target);
      ALU_LW:      word = i_word(OPC_LW, rs, rt, imm);
      ALU_SW:      word = i_word(OPC_SW, rs, rt, imm);
      ALU_ADDI:    word = i_word(OPC_ADDI, rs, rt, imm);
      ALU_BNE:     word = i_word(OPC_BNE, rs, rt, imm);
      ALU_ILLEGAL: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: encodes requests into MIPS words and presents them
// with sequential byte addresses through a one-deep output register.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int  ADDR_W    = 8,
  parameter int  MEM_WORDS = 64,
  localparam int CNT_W     = $clog2(MEM_WORDS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              err
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;
  logic              retire;

  instr_enc_word u_enc (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .target  (in_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign full      = (count == CNT_W'(MEM_WORDS));
  // Reset gates ready combinationally so nothing is offered while it is held.
  assign in_ready  = !reset && !base_load && !full && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  // Address wraps modulo 2^ADDR_W; the cast truncates the scaled count.
  assign word_addr = base + ADDR_W'({count, 2'b00});

  // Output register, base/count bookkeeping and sticky illegal-op flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_addr  <= '0;
      base      <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (retire) out_valid <= 1'b0;
      if (base_load) begin
        // A pending word keeps the address it was captured with.
        base  <= base_addr & ~ADDR_W'(3);
        count <= '0;
        err   <= 1'b0;
      end else if (accept) begin
        if (enc_illegal) begin
          err <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_data  <= enc_word;
          out_addr  <= word_addr;
          count     <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder, the inverse of the ID-stage control decoder: it accepts compact operation requests over a valid/ready handshake and emits 32-bit MIPS instruction words with sequential addresses into the instruction-memory write port. The program loader and test harness use it to populate instruction memory before the pipeline runs. Opcodes and funct fields match the decoder exactly, so decode(encode(op)) returns the requested 4-bit ALUOp.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of the instruction-memory write port.
- MEM_WORDS, 64, maximum words written after each base load; must be at most 2^(ADDR_W-2).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- base_load  in  1  load base_addr, clear count and err.
- base_addr  in  ADDR_W  start byte address; bits [1:0] are ignored and treated as 0.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  4  ALUOp code: 0 noop, 1 add, 2 sub, 3 and, 4 or, 5 mult, 6 xor, 7 nor, 8 slt, 9 beq, 10 j, 11 lw, 12 sw, 13 addi, 14 bne, 15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate for beq, bne, lw, sw and addi.
- in_target  in  26  jump target.
- out_valid  out  1  instruction word pending.
- out_ready  in  1  memory accepts the word this cycle.
- out_addr  out  ADDR_W  byte address of the word.
- out_data  out  32  instruction word.
- count  out  $clog2(MEM_WORDS)+1  words accepted since the last base load.
- full  out  1  count == MEM_WORDS.
- err  out  1  sticky flag: an illegal op was seen.

## Operation
- Encoding rules:
  - R-type (ops 1-8): {6'b0, rs, rt, rd, 5'b0, funct}. funct values: add 100000, sub 100010, and 100100, or 100101, mult 011000, xor 100110, nor 100111, slt 101010.
  - Noop (op 0): 32'h0.
  - j (op 10): {000010, target}.
  - I-type: {opcode, rs, rt, imm}. opcodes: beq 000100, bne 000101, lw 100011, sw 101011, addi 001000.
- in_ready = !reset && !base_load && !full && (!out_valid || out_ready).
- Legal accept:
  - Output register loads the encoded word, with out_addr = base + 4*count (truncated to ADDR_W, wrapping modulo 2^ADDR_W).
  - count increments by 1 and out_valid is set.
- Illegal accept (op 15):
  - Request is consumed and err is set.
  - No word is emitted and count is unchanged.
  - out_valid clears if out_ready was high; otherwise the pending word holds.
- Output handshake: out_valid && out_ready retires the word; it clears out_valid unless a new legal word is accepted in the same cycle.
- base_load:
  - Has priority over a request in the same cycle; in_ready is low that cycle.
  - Sets base, count = 0, err = 0.
  - A pending output word is kept with its already captured address.
- Full: once count == MEM_WORDS, in_ready stays low until base_load or reset. The pending word still drains.
- Reset (asynchronous, also mid-operation): out_valid = 0, out_data = 0, out_addr = 0, base = 0, count = 0, full = 0, err = 0. Any pending word is discarded.

## Timing
- Latency is 1 cycle: a request accepted at edge N appears with out_valid = 1 after edge N.
- Throughput is 1 word/cycle while out_ready is held high.
- While out_valid && !out_ready: out_data and out_addr hold stable and in_ready = 0.
- count and full update on the same edge as acceptance; err updates on the accepting edge.
- full rises on the edge that accepts word MEM_WORDS; in_ready drops combinationally after that edge.

## Structure
- Shared package mips_pkg holds:
  - 4-bit ALUOp code constants (shared with the control decoder).
  - 6-bit opcode and funct constants.
  - Instruction field position constants.
- Sub-module instr_enc_word: purely combinational in_op plus fields to {word, illegal}.
- instr_encoder holds the handshake, output register, base register, count and err.

## Test plan
- Reset, base_load 0x10, then add rs=1 rt=2 rd=3 with out_ready=1 -> out_data 0x00221820, out_addr 0x10, count 1.
- Back-to-back beq rs=1 rt=2 imm=0xFFFF, then j target=0x0000040 -> 0x1022FFFF @0x10, then 0x08000040 @0x14; one word per cycle.
- Hold out_ready=0 for 3 cycles with a second request waiting -> in_ready=0, out_data stable; the second word appears on the cycle after out_ready rises.
- Illegal op 15 between lw rs=0 rt=4 imm=8 and sw -> err=1, no word for op 15; lw 0x8C040008 and sw at consecutive addresses; count 2.
- MEM_WORDS=4: send 5 requests -> full=1 after the 4th, 5th request stalls; base_load 0x40 -> count 0, full 0, 5th request written @0x40.
- Assert reset while out_valid=1 and out_ready=0 -> out_valid, count, err and out_addr are 0 immediately, without waiting for a clock edge.
